alu_req_driver: RTL and testbench

ALU_REQ_DRIVER -- requirements
Module: alu_req_driver

---
 rtl/alu_req_driver.sv | 149 ++++++++++++++
 tb/tb_alu_req_driver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_driver.sv
// rtl/alu_req_driver.sv - queued request driver for an attached combinational ALU
// Requests queue in a FIFO, are presented to the ALU for SETTLE cycles, then answered in order.
module alu_req_driver #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_opcode,
    input  logic [WIDTH-1:0]       req_a,
    input  logic [WIDTH-1:0]       req_b,
    input  logic [4:0]             req_shift,
    input  logic [3:0]             req_tag,
    output logic [3:0]             alu_opcode,
    output logic [WIDTH-1:0]       alu_input1,
    output logic [WIDTH-1:0]       alu_input2,
    output logic [4:0]             alu_shiftValue,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_carryFlag,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_carry,
    output logic [3:0]             rsp_tag,
    output logic                   rsp_illegal,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] LAST_LEGAL = 4'd10;

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [4:0]       shift;
        logic [3:0]       tag;
    } cmd_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic [3:0]    settle_cnt;
    logic [3:0]    cur_tag;
    cmd_t          head;
    logic          full;
    logic          push;
    logic          pop;

    assign head      = mem[rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign req_ready = !full;
    assign push      = req_valid && !full;
    // Pop from IDLE, or straight out of RESP on the handshake edge so there is no idle bubble.
    assign pop       = (count != '0) && ((state == IDLE) || (state == RESP && rsp_ready));
    assign pending   = count;
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {req_opcode, req_a, req_b, req_shift, req_tag};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            cur_tag        <= '0;
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
            rsp_valid      <= 1'b0;
            rsp_result     <= '0;
            rsp_carry      <= 1'b0;
            rsp_tag        <= '0;
            rsp_illegal    <= 1'b0;
        end else if (pop) begin
            if (head.opcode > LAST_LEGAL) begin
                // Illegal opcodes never reach the ALU; answer immediately.
                state          <= RESP;
                rsp_valid      <= 1'b1;
                rsp_illegal    <= 1'b1;
                rsp_result     <= '0;
                rsp_carry      <= 1'b0;
                rsp_tag        <= head.tag;
                alu_opcode     <= '0;
                alu_input1     <= '0;
                alu_input2     <= '0;
                alu_shiftValue <= '0;
            end else begin
                state          <= DRIVE;
                settle_cnt     <= 4'(SETTLE - 1);
                cur_tag        <= head.tag;
                rsp_valid      <= 1'b0;
                alu_opcode     <= head.opcode;
                alu_input1     <= head.a;
                alu_input2     <= head.b;
                alu_shiftValue <= head.shift;
            end
        end else begin
            case (state)
                DRIVE: begin
                    if (settle_cnt == '0) begin
                        state          <= RESP;
                        rsp_valid      <= 1'b1;
                        rsp_illegal    <= 1'b0;
                        rsp_result     <= alu_result;
                        rsp_carry      <= alu_carryFlag;
                        rsp_tag        <= cur_tag;
                        alu_opcode     <= '0;
                        alu_input1     <= '0;
                        alu_input2     <= '0;
                        alu_shiftValue <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_driver.sv
// tb/tb_alu_req_driver.sv - scoreboard bench for alu_req_driver
module tb_alu_req_driver;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid, req_ready;
    logic [3:0]    req_opcode;
    logic [W-1:0]  req_a, req_b;
    logic [4:0]    req_shift;
    logic [3:0]    req_tag;
    logic [3:0]    alu_opcode;
    logic [W-1:0]  alu_input1, alu_input2;
    logic [4:0]    alu_shiftValue;
    logic [W-1:0]  alu_result;
    logic          alu_carryFlag;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_carry;
    logic [3:0]    rsp_tag;
    logic          rsp_illegal;
    logic          busy;
    logic [2:0]    pending;

    logic          req_valid3, req_ready3;
    logic [3:0]    req_opcode3;
    logic [W-1:0]  req_a3, req_b3;
    logic [4:0]    req_shift3;
    logic [3:0]    req_tag3;
    logic [3:0]    alu_opcode3;
    logic [W-1:0]  alu_input13, alu_input23;
    logic [4:0]    alu_shiftValue3;
    logic [W-1:0]  alu_result3;
    logic          alu_carryFlag3;
    logic          rsp_valid3, rsp_ready3;
    logic [W-1:0]  rsp_result3;
    logic          rsp_carry3;
    logic [3:0]    rsp_tag3;
    logic          rsp_illegal3;
    logic          busy3;
    logic [2:0]    pending3;

    // Reference ALU: carry is bit W of the returned word.
    function automatic logic [W:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [4:0] sh);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            4'd0:    return {1'b0, a & b};
            4'd1:    return {1'b0, a} + {1'b0, b};
            4'd2:    return {1'b0, a} - {1'b0, b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            4'd5:    return {1'b0, a} << sh;
            4'd6:    return {1'b0, a >> sh};
            4'd7:    return {|prod[2*W-1:W], prod[W-1:0]};
            4'd8:    return (b == '0) ? {1'b1, {W{1'b1}}} : {1'b0, a / b};
            4'd9:    return {1'b0, ~a};
            4'd10:   return (b == '0) ? {1'b1, a} : {1'b0, a % b};
            default: return '0;
        endcase
    endfunction

    function automatic logic [13:0] expect_word(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [4:0] sh,
                                                input logic [3:0] tag);
        logic [W:0] r;
        if (op > 4'd10) return {1'b1, tag, 1'b0, {W{1'b0}}};
        r = alu_model(op, a, b, sh);
        return {1'b0, tag, r[W], r[W-1:0]};
    endfunction

    assign {alu_carryFlag, alu_result}   = alu_model(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
    assign {alu_carryFlag3, alu_result3} = alu_model(alu_opcode3, alu_input13, alu_input23, alu_shiftValue3);

    alu_req_driver #(.WIDTH(W), .DEPTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_shift(req_shift), .req_tag(req_tag),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_carryFlag(alu_carryFlag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
        .busy(busy), .pending(pending)
    );

    alu_req_driver #(.WIDTH(W), .DEPTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_opcode(req_opcode3), .req_a(req_a3), .req_b(req_b3), .req_shift(req_shift3), .req_tag(req_tag3),
        .alu_opcode(alu_opcode3), .alu_input1(alu_input13), .alu_input2(alu_input23),
        .alu_shiftValue(alu_shiftValue3), .alu_result(alu_result3), .alu_carryFlag(alu_carryFlag3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_carry(rsp_carry3), .rsp_tag(rsp_tag3), .rsp_illegal(rsp_illegal3),
        .busy(busy3), .pending(pending3)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    logic [13:0] exp_q[$];
    logic        hold = 1'b0;
    logic [13:0] hold_val = '0;
    int          rsp_cnt = 0;
    bit          rand_rdy = 1'b0;
    wire  [13:0] rsp_word = {rsp_illegal, rsp_tag, rsp_carry, rsp_result};

    // Monitor samples mid-cycle: whatever is valid&&ready here is taken at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold <= 1'b0;
        end else begin
            if (hold) check("hold_stable", 32'({rsp_valid, rsp_word}), 32'({1'b1, hold_val}));
            if (rsp_valid)
                check("alu_zero_in_resp", 32'({alu_opcode, alu_input1, alu_input2, alu_shiftValue}), 32'd0);
            if (req_valid && req_ready)
                exp_q.push_back(expect_word(req_opcode, req_a, req_b, req_shift, req_tag));
            if (rsp_valid && rsp_ready) begin
                rsp_cnt <= rsp_cnt + 1;
                if (exp_q.size() == 0) check("unexpected_rsp", 32'(rsp_word), 32'hFFFF_FFFF);
                else check("rsp_payload", 32'(rsp_word), 32'(exp_q.pop_front()));
            end
            hold     <= rsp_valid && !rsp_ready;
            hold_val <= rsp_word;
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input logic [3:0] tag);
        int n = 0;
        bit acc = 1'b0;
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_shift = sh; req_tag = tag;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = req_ready;
            n++;
            @(posedge clk); #1;
            if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        end
        req_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", 32'(busy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int  c0;
        int  stable;
        bit  got;
        rst = 1'b1;
        req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; req_shift = '0; req_tag = '0;
        rsp_ready = 1'b1;
        req_valid3 = 1'b0; req_opcode3 = '0; req_a3 = '0; req_b3 = '0; req_shift3 = '0; req_tag3 = '0;
        rsp_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_alu", 32'({alu_opcode, alu_input1, alu_input2, alu_shiftValue}), 32'd0);
        check("rst_rsp_word", 32'(rsp_word), 32'd0);
        check("rst3_idle", 32'({busy3, pending3, rsp_valid3}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single ADD: latency and payload
        send(4'd1, 8'hF0, 8'h20, 5'd0, 4'd3);
        @(negedge clk);
        check("lat_e0_rsp_valid", 32'(rsp_valid), 32'd0);
        check("lat_e0_pending", 32'(pending), 32'd1);
        @(negedge clk);
        check("lat_e1_alu", 32'({alu_opcode, alu_input1, alu_input2}), 32'h1F020);
        check("lat_e1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_e2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("add_result", 32'(rsp_result), 32'h10);
        check("add_carry", 32'(rsp_carry), 32'd1);
        check("add_tag", 32'(rsp_tag), 32'd3);
        check("add_illegal", 32'(rsp_illegal), 32'd0);
        drain();

        // Illegal opcode never drives the ALU
        send(4'd12, 8'h55, 8'hAA, 5'd3, 4'd5);
        @(negedge clk);
        check("ill_alu_e0", 32'(alu_opcode), 32'd0);
        @(negedge clk);
        check("ill_alu_e1", 32'(alu_opcode), 32'd0);
        check("ill_rsp", 32'({rsp_valid, rsp_illegal, rsp_tag, rsp_carry, rsp_result}), 32'({1'b1, 1'b1, 4'd5, 1'b0, 8'h00}));
        drain();

        // Back-pressure: five requests, FIFO fills to DEPTH
        rsp_ready = 1'b0;
        c0 = rsp_cnt;
        for (int i = 0; i < 5; i++) send(4'(i % 4 + 1), 8'(17 * i + 3), 8'(i + 1), 5'(i), 4'(i + 8));
        @(negedge clk);
        check("full_pending", 32'(pending), 32'd4);
        check("full_req_ready", 32'(req_ready), 32'd0);
        check("full_rsp_valid", 32'(rsp_valid), 32'd1);
        drain();
        check("burst_count", 32'(rsp_cnt - c0), 32'd5);

        // SETTLE=3 instance: DIV held three cycles
        req_valid3 = 1'b1; req_opcode3 = 4'd8; req_a3 = 8'h64; req_b3 = 8'h07; req_shift3 = 5'd0; req_tag3 = 4'd9;
        @(negedge clk);
        check("div_req_ready", 32'(req_ready3), 32'd1);
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        stable = 0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (alu_opcode3 != 4'd0) begin
                stable++;
                check("settle_ports", 32'({alu_opcode3, alu_input13, alu_input23}), 32'h86407);
            end
            if (rsp_valid3) begin
                got = 1'b1;
                check("div_rsp", 32'({rsp_illegal3, rsp_tag3, rsp_carry3, rsp_result3}), 32'({1'b0, 4'd9, 1'b0, 8'h0E}));
            end
        end
        check("div_rsp_seen", 32'(got), 32'd1);
        check("settle_cycles", 32'(stable), 32'd3);
        @(posedge clk); #1;

        // Reset while in DRIVE with two queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'd1, 8'(i), 8'(i), 5'd0, 4'(i));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_pending", 32'(pending), 32'd2);
        check("pre_rst_drive", 32'({rsp_valid, alu_opcode}), 32'h01);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pending", 32'(pending), 32'd0);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b1;
        c0 = rsp_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(rsp_valid), 32'd0);
        end
        check("post_rst_count", 32'(rsp_cnt - c0), 32'd0);
        @(posedge clk); #1;

        // Random mix with random response back-pressure
        rand_rdy = 1'b1;
        c0 = rsp_cnt;
        for (int i = 0; i < 100; i++)
            send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 5'($urandom_range(0, 7)), 4'(i));
        drain();
        check("rand_count", 32'(rsp_cnt - c0), 32'd100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
